// File: rtl/cdc_fifo_burst_reader_if.sv
// Bus bundle for cdc_fifo_burst_reader: FIFO read port plus framed downstream stream.
// The slave view belongs to the reader; the master view is the environment (FIFO + consumer).
interface cdc_fifo_burst_reader_if #(
    parameter int SIZE      = 4,
    parameter int DAT_BITS  = 8,
    parameter int BURST_LEN = 4
);
    localparam int ABITS = $clog2(SIZE);
    localparam int LBITS = $clog2(BURST_LEN + 1);

    // FIFO read side
    logic                i_val;
    logic [DAT_BITS-1:0] i_dat;
    logic                o_rdy;
    logic                i_emp;
    logic [ABITS:0]      i_wrds;

    // Downstream burst side
    logic                o_val;
    logic [DAT_BITS-1:0] o_dat;
    logic                o_sop;
    logic                o_eop;
    logic [LBITS-1:0]    o_len;
    logic                i_rdy;

    modport slave (
        input  i_val, i_dat, i_emp, i_wrds, i_rdy,
        output o_rdy, o_val, o_dat, o_sop, o_eop, o_len
    );

    modport master (
        output i_val, i_dat, i_emp, i_wrds, i_rdy,
        input  o_rdy, o_val, o_dat, o_sop, o_eop, o_len
    );
endinterface

// File: rtl/cdc_fifo_burst_reader.sv
// Drains the read side of a CDC FIFO into sop/eop-framed bursts of BURST_LEN words,
// flushing a shorter burst after TIMEOUT idle cycles. Optional: CDC_FIFO_BURST_READER_STATS_EN.
module cdc_fifo_burst_reader #(
    parameter int SIZE      = 4,
    parameter int DAT_BITS  = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    cdc_fifo_burst_reader_if.slave        bus
`ifdef CDC_FIFO_BURST_READER_STATS_EN
    ,
    output logic [15:0]                   o_full_cnt,
    output logic [15:0]                   o_flush_cnt
`endif
);
    localparam int ABITS = $clog2(SIZE);
    localparam int LBITS = $clog2(BURST_LEN + 1);
    localparam int TBITS = $clog2(TIMEOUT + 1);

    localparam logic [ABITS:0]   SIZE_W    = (ABITS + 1)'(SIZE);
    localparam logic [ABITS:0]   BURST_W   = (ABITS + 1)'(BURST_LEN);
    localparam logic [LBITS-1:0] BURST_L   = LBITS'(BURST_LEN);
    localparam logic [TBITS-1:0] TIMEOUT_T = TBITS'(TIMEOUT);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t               state_q, state_d;
    logic [TBITS-1:0]     timer_q;
    logic [LBITS-1:0]     len_q;
    logic [LBITS-1:0]     beat_q;
    logic [ABITS:0]       fill;
    logic                 full_start;
    logic                 flush_start;
    logic                 pop;
    logic                 accept;
    logic                 last_beat;

    logic                 val_q;
    logic [DAT_BITS-1:0]  dat_q;
    logic                 sop_q;
    logic                 eop_q;
    logic [LBITS-1:0]     olen_q;

    // A full FIFO wraps the fill report to zero in its low bits; i_emp disambiguates.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        fill = bus.i_wrds;
        if (bus.i_emp) begin
            fill = '0;
        end else if (bus.i_wrds[ABITS-1:0] == '0) begin
            fill = SIZE_W;
        end
    end

    assign full_start  = (state_q == IDLE) && (fill >= BURST_W);
    assign flush_start = (state_q == IDLE) && !full_start
                         && (timer_q == TIMEOUT_T) && (fill != '0);
    assign last_beat   = (beat_q == len_q - LBITS'(1));
    assign accept      = pop && bus.i_val;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers sample together.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_start || flush_start) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                pop = (!val_q || bus.i_rdy) && (beat_q < len_q);
                if (pop && bus.i_val && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush timer only runs while a partial burst is waiting in IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer_q <= '0;
        end else if (state_q == IDLE) begin
            if (fill == '0 || full_start || flush_start) begin
                timer_q <= '0;
            end else if (fill < BURST_W && timer_q != TIMEOUT_T) begin
                timer_q <= timer_q + TBITS'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_q  <= '0;
            beat_q <= '0;
        end else begin
            if (full_start) begin
                len_q <= BURST_L;
            end else if (flush_start) begin
                len_q <= LBITS'(fill);
            end
            if (accept) begin
                beat_q <= last_beat ? '0 : beat_q + LBITS'(1);
            end
        end
    end

    // Output register: loads on every accepted beat, empties when taken without a refill.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            val_q  <= 1'b0;
            dat_q  <= '0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
            olen_q <= '0;
        end else if (accept) begin
            val_q <= 1'b1;
            dat_q <= bus.i_dat;
            sop_q <= (beat_q == '0);
            eop_q <= last_beat;
            if (beat_q == '0) begin
                olen_q <= len_q;
            end
        end else if (val_q && bus.i_rdy) begin
            val_q <= 1'b0;
        end
    end

    assign bus.o_rdy = pop;
    assign bus.o_val = val_q;
    assign bus.o_dat = dat_q;
    assign bus.o_sop = sop_q;
    assign bus.o_eop = eop_q;
    assign bus.o_len = olen_q;

`ifdef CDC_FIFO_BURST_READER_STATS_EN
    logic [15:0] full_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (full_start && full_cnt_q != 16'hFFFF) begin
                full_cnt_q <= full_cnt_q + 16'd1;
            end
            if (flush_start && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign o_full_cnt  = full_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: doc/cdc_fifo_burst_reader.md
Name: cdc_fifo_burst_reader

Overview:
- Single-clock consumer for the read side of the CDC FIFO.
- Drains FIFO words and emits framed bursts downstream with sop/eop and a burst length.
- A burst starts when BURST_LEN words are available. If fewer words sit in the FIFO for TIMEOUT cycles, a shorter flush burst is emitted.
- Sits between the FIFO read port and a packet-oriented consumer.

Parameters:
- SIZE, 4, depth of the feeding FIFO (power of 2); ABITS = $clog2(SIZE).
- DAT_BITS, 8, data width.
- BURST_LEN, 4, words per full burst; 1 <= BURST_LEN <= SIZE; LBITS = $clog2(BURST_LEN+1).
- TIMEOUT, 16, idle cycles with pending data before a flush burst; >= 1; TBITS = $clog2(TIMEOUT+1).

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_val  in  1  FIFO head word valid.
- i_dat  in  DAT_BITS  FIFO head word.
- o_rdy  out  1  pop strobe to FIFO; a beat is accepted when i_val && o_rdy.
- i_emp  in  1  FIFO empty flag.
- i_wrds  in  ABITS+1  FIFO fill report.
- o_val  out  1  downstream valid.
- o_dat  out  DAT_BITS  downstream data.
- o_sop  out  1  first beat of burst, qualified by o_val.
- o_eop  out  1  last beat of burst, qualified by o_val.
- o_len  out  LBITS  length of current burst; stable for the whole burst.
- i_rdy  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release):
  - o_val, o_sop, o_eop, o_dat, o_len = 0; o_rdy = 0.
  - State IDLE; all counters 0.
  - A burst in progress when reset asserts is discarded and never resumed.
- Fill decode, combinational:
  - fill = 0 if i_emp.
  - fill = SIZE if !i_emp and i_wrds[ABITS-1:0] == 0.
  - fill = i_wrds otherwise.
  - fill may under-report (pointer sync lag) but never over-reports, so a latched length is always satisfiable.
- IDLE state:
  - o_rdy = 0.
  - Timer counts up by 1 per cycle while fill > 0 and fill < BURST_LEN, saturating at TIMEOUT. Cleared when fill == 0 or when a burst starts.
  - If fill >= BURST_LEN: latch len = BURST_LEN, go to BURST.
  - Else if timer == TIMEOUT and fill > 0: latch len = fill, go to BURST (flush).
  - The full-burst condition has priority over the flush condition.
- BURST state:
  - o_rdy = (~o_val || i_rdy) && (beat < len).
  - Each accepted beat loads the output register: o_dat <= i_dat, o_val <= 1, o_sop <= (beat == 0), o_eop <= (beat == len-1); beat increments.
  - If o_val && i_rdy and no new beat is accepted in the same cycle, o_val <= 0.
  - When the beat with index len-1 is accepted: beat <= 0, return to IDLE.
  - The output register may still hold the eop beat while IDLE evaluates a new start. The next burst's first beat loads only when the register frees (or is accepted in the same cycle).
  - o_len updates when the first beat of a burst loads, not earlier.
- Latency: from the IDLE cycle where the start condition holds, the first o_val is 2 cycles later, given i_val = 1.
- Upstream bubbles (i_val = 0) mid-burst: the burst stalls without error. o_val deasserts once the held beat drains; the beat count is preserved.
- Backpressure (i_rdy = 0 with o_val = 1): o_val, o_dat, o_sop, o_eop, o_len are held stable; o_rdy = 0.
- Full throughput: one beat per cycle when i_val and i_rdy are continuously high.

Optional Feature:
- Macro: CDC_FIFO_BURST_READER_STATS_EN.
- When defined, adds two outputs:
  - o_full_cnt [15:0]: increments on each full-burst start.
  - o_flush_cnt [15:0]: increments on each flush-burst start.
  - Both saturate at 16'hFFFF and are cleared by reset.
- When undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Parameters for all scenarios: SIZE=8, BURST_LEN=4, TIMEOUT=16, DAT_BITS=8.
- Full burst: fill reaches 4 with words 0x10..0x13, i_rdy=1 -> o_val rises 2 cycles later; 4 consecutive beats 0x10,0x11,0x12,0x13; o_sop on 0x10, o_eop on 0x13, o_len=4.
- Timeout flush: 2 words 0xA0,0xA1 and no further writes -> no o_rdy for 16 cycles, then burst len 2; o_sop on 0xA0, o_eop on 0xA1, o_len=2.
- Backpressure: i_rdy=0 for 3 cycles after beat 1 of a 4-beat burst -> o_dat=beat 1 value held and o_rdy=0 for 3 cycles; all 4 beats delivered in order, none lost.
- Full-FIFO decode: i_emp=0, i_wrds=4'b1000 (low bits 0) -> treated as fill=8; full burst of 4 starts, followed immediately by a second burst of 4 with sop on word 5.
- Reset mid-burst: assert i_rst_n=0 after 2 beats -> o_val=0 asynchronously; after release with fill=4, the next o_val has o_sop=1 and o_len=4.
- With CDC_FIFO_BURST_READER_STATS_EN: 3 full bursts and 1 flush -> o_full_cnt=3, o_flush_cnt=1; both 0 after reset.
